// File: rtl/button_debounce_scheduler.sv
// Round-robin debounce controller: one shared stability counter services N_BTN
// synchronized buttons and reports accepted level changes as a valid/ready event stream.
module button_debounce_scheduler #(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned STABLE_CNT = 19,
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned ID_W       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] button,
    output logic [N_BTN-1:0] level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_dir,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;

    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_BTN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [N_BTN-1:0] sync_meta;
    logic [N_BTN-1:0] sync_q;
    logic [N_BTN-1:0] pending;

    logic [1:0]       state_q,   state_d;
    logic [ID_W-1:0]  sel_q,     sel_d;
    logic             target_q,  target_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [ID_W-1:0]  rr_ptr_q,  rr_ptr_d;
    logic [N_BTN-1:0] level_d;
    logic             evt_valid_d;
    logic [ID_W-1:0]  evt_id_d;
    logic             evt_dir_d;

    logic             found;
    logic [ID_W-1:0]  pick;
    logic [ID_W-1:0]  sel_inc;

    // A button needs service whenever its synchronized value disagrees with its accepted level
    assign pending = sync_q ^ level;
    assign sel_inc = (sel_q == LAST_ID) ? '0 : sel_q + ID_W'(1);

    // First pending index at or above rr_ptr, wrapping around
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= N_BTN) begin
                idx = idx - N_BTN;
            end
            if (!found && pending[ID_W'(idx)]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        level_d     = level;
        evt_valid_d = evt_valid;
        evt_id_d    = evt_id;
        evt_dir_d   = evt_dir;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    sel_d    = pick;
                    target_d = ~level[pick];
                    cnt_d    = '0;
                    state_d  = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (sync_q[sel_q] != target_q) begin
                    rr_ptr_d = sel_inc;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    level_d[sel_q] = target_q;
                    evt_valid_d    = 1'b1;
                    evt_id_d       = sel_q;
                    evt_dir_d      = target_q;
                    state_d        = ST_EMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EMIT: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    rr_ptr_d    = sel_inc;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            target_q  <= 1'b0;
            cnt_q     <= '0;
            rr_ptr_q  <= '0;
            level     <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_dir   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sync_meta <= button;
            sync_q    <= sync_meta;
            state_q   <= state_d;
            sel_q     <= sel_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            level     <= level_d;
            evt_valid <= evt_valid_d;
            evt_id    <= evt_id_d;
            evt_dir   <= evt_dir_d;
            busy      <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_button_debounce_scheduler.sv
// Randomized and directed bench for button_debounce_scheduler, checked every cycle
// against a behavioural model of the debounce/scheduling rules.
module tb_button_debounce_scheduler;

    localparam int unsigned N_BTN      = 4;
    localparam int unsigned STABLE_CNT = 19;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned ID_W       = 2;

    logic             clk;
    logic             rst_n;
    logic [N_BTN-1:0] button;
    logic [N_BTN-1:0] level;
    logic             evt_valid;
    logic             evt_ready;
    logic [ID_W-1:0]  evt_id;
    logic             evt_dir;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    int evt_cnt = 0;
    logic [7:0] evq[$];

    button_debounce_scheduler #(
        .N_BTN(N_BTN), .STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button(button), .level(level),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_dir(evt_dir), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({level, evt_valid, evt_id, evt_dir, busy});
    endfunction

    // Behavioural model: a button is "being watched" until it either stays at its
    // new value for STABLE_CNT samples (event) or deviates (give up, move on).
    logic [N_BTN-1:0] m_s1, m_s2, m_level;
    logic             m_active, m_valid, m_dir, m_tgt;
    logic [ID_W-1:0]  m_id;
    int               m_sel, m_run, m_rr;

    always @(posedge clk or negedge rst_n) begin
        logic [N_BTN-1:0] seen;
        logic [N_BTN-1:0] want;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_level = '0;
            m_active = 0; m_valid = 0; m_dir = 0; m_tgt = 0;
            m_id = '0; m_sel = 0; m_run = 0; m_rr = 0;
        end else begin
            seen = m_s2;
            want = m_s2 ^ m_level;
            m_s2 = m_s1;
            m_s1 = button;
            if (!m_active) begin
                for (int k = 0; k < N_BTN; k++) begin
                    int j;
                    j = (m_rr + k) % N_BTN;
                    if (want[j]) begin
                        m_active = 1; m_sel = j; m_tgt = !m_level[j]; m_run = 0;
                        break;
                    end
                end
            end else if (m_valid) begin
                if (evt_ready) begin
                    m_valid = 0; m_active = 0; m_rr = (m_sel + 1) % N_BTN;
                end
            end else if (seen[m_sel] != m_tgt) begin
                m_active = 0; m_rr = (m_sel + 1) % N_BTN;
            end else begin
                m_run++;
                if (m_run == STABLE_CNT) begin
                    m_level[m_sel] = m_tgt;
                    m_valid = 1; m_id = ID_W'(m_sel); m_dir = m_tgt;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("outs", outs(), 32'({m_level, m_valid, m_id, m_dir, m_active}));
        if (rst_n && evt_valid && evt_ready) begin
            evt_cnt++;
            evq.push_back(8'({evt_id, evt_dir}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        button = '0;
        evt_ready = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        evq.delete();
    endtask

    task automatic wait_evt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!evt_valid && n < 100);
    endtask

    task automatic wait_q(input int k);
        int n;
        n = 0;
        while (evq.size() < k && n < 300) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int base;
        logic [7:0] rr_exp [6];
        logic [N_BTN-1:0] stab;
        int bl [N_BTN];
        int rdy_run;

        rst_n = 1'b0; button = '0; evt_ready = 1'b0;
        #12;
        chk("reset_state", outs(), 32'h0);
        reset_dut();

        // Clean press and release latency
        button[1] = 1'b1;
        wait_evt(n);
        chk("press_lat", 32'(n), 32'(STABLE_CNT + 3));
        chk("press_id", 32'(evt_id), 32'd1);
        chk("press_dir", 32'(evt_dir), 32'd1);
        chk("press_lvl", 32'(level), 32'h2);
        tick();
        chk("press_one_cycle", 32'(evt_valid), 32'd0);
        button[1] = 1'b0;
        wait_evt(n);
        chk("release_lat", 32'(n), 32'(STABLE_CNT + 3));
        chk("release_dir", 32'(evt_dir), 32'd0);

        // Bounce rejection
        reset_dut();
        base = evt_cnt;
        for (int t = 0; t < 12; t++) begin
            button[0] = ~button[0];
            repeat (5) tick();
        end
        chk("bounce_quiet", 32'(evt_cnt - base), 32'd0);
        button[0] = 1'b1;
        wait_evt(n);
        chk("bounce_lat", 32'(n), 32'(STABLE_CNT + 3));
        tick();
        chk("bounce_one", 32'(evt_cnt - base), 32'd1);

        // Glitch landing on the final counting sample
        reset_dut();
        base = evt_cnt;
        button[2] = 1'b1;
        repeat (19) tick();
        button[2] = 1'b0;
        tick();
        button[2] = 1'b1;
        repeat (2) tick();
        chk("glitch_lvl", 32'(level[2]), 32'd0);
        chk("glitch_busy", 32'(busy), 32'd0);
        chk("glitch_noevt", 32'(evt_cnt - base), 32'd0);
        repeat (30) tick();
        chk("glitch_retry", 32'(level[2]), 32'd1);

        // Round-robin ordering
        reset_dut();
        rr_exp[0] = 8'h1; rr_exp[1] = 8'h7; rr_exp[2] = 8'h0;
        rr_exp[3] = 8'h6; rr_exp[4] = 8'h1; rr_exp[5] = 8'h5;
        button = 4'b1001;
        wait_q(2);
        button = 4'b0000;
        wait_q(4);
        button = 4'b0101;
        wait_q(6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_evt%0d", i), 32'((i < evq.size()) ? evq[i] : 8'hff), 32'(rr_exp[i]));
        end

        // Backpressure
        reset_dut();
        evt_ready = 1'b0;
        button[1] = 1'b1;
        wait_evt(n);
        button[2] = 1'b1;
        repeat (100) tick();
        chk("bp_valid", 32'(evt_valid), 32'd1);
        chk("bp_id", 32'(evt_id), 32'd1);
        chk("bp_dir", 32'(evt_dir), 32'd1);
        chk("bp_lvl2", 32'(level[2]), 32'd0);
        evt_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(evt_valid && evt_id == 2'd2) && n < 100);
        chk("bp_lat", 32'(n), 32'(STABLE_CNT + 2));
        chk("bp_lvl", 32'(level), 32'h6);

        // Asynchronous reset mid-COUNT
        repeat (3) tick();
        button[3] = 1'b1;
        repeat (10) tick();
        #1 rst_n = 1'b0;
        #1 chk("rst_count", outs(), 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (120) tick();
        chk("rst_count_redo", 32'(level), 32'he);

        // Asynchronous reset mid-EMIT
        evt_ready = 1'b0;
        button[0] = 1'b1;
        wait_evt(n);
        #1 rst_n = 1'b0;
        #1 chk("rst_emit", outs(), 32'h0);
        tick();
        rst_n = 1'b1;
        evt_ready = 1'b1;
        repeat (150) tick();
        chk("rst_emit_redo", 32'(level), 32'hf);

        // Randomized bouncing buttons, random backpressure and occasional resets
        stab = button;
        rdy_run = 0;
        for (int i = 0; i < N_BTN; i++) bl[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            for (int i = 0; i < N_BTN; i++) begin
                if (bl[i] > 0) begin
                    bl[i]--;
                    button[i] = (bl[i] == 0) ? stab[i] : 1'($urandom_range(0, 1));
                end else if ($urandom_range(0, 59) == 0) begin
                    stab[i] = ~stab[i];
                    bl[i] = $urandom_range(0, 12);
                    button[i] = (bl[i] == 0) ? stab[i] : ~stab[i];
                end
            end
            if (rdy_run == 0) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                rdy_run = evt_ready ? $urandom_range(1, 20) : $urandom_range(1, 40);
            end else begin
                rdy_run--;
            end
            if ($urandom_range(0, 1499) == 0) begin
                #1 rst_n = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/button_debounce_scheduler.md
# button_debounce_scheduler

Time-multiplexed debounce controller: one shared stability counter is scheduled round-robin across N_BTN raw button inputs. It sits between the board push-buttons and the user logic. It produces debounced levels plus a press/release event stream with a valid/ready handshake, replacing one counter per button.

## Interface
- N_BTN, 4, number of button inputs (2..8)
- STABLE_CNT, 19, consecutive stable cycles required to accept a change (>=2)
- CNT_W, 6, stability counter width; must satisfy 2^CNT_W > STABLE_CNT
- ID_W, 2, event index width; must satisfy 2^ID_W >= N_BTN
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- button  in  N_BTN  raw asynchronous buttons, active-high (1 = pressed)
- level  out  N_BTN  debounced button levels
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_id  out  ID_W  index of button that changed
- evt_dir  out  1  1 = press (0->1), 0 = release (1->0)
- busy  out  1  scheduler not in IDLE

## Operation
- Each button passes through a 2-flop synchronizer: sync[i].
- pending[i] = sync[i] != level[i] (combinational).
- State machine: IDLE, COUNT, EMIT. Registers: sel (ID_W), target (1), cnt (CNT_W), rr_ptr (ID_W).
- IDLE: if any pending bit is set, select the first pending index searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., N_BTN-1, 0, ...). Load sel, set target = ~level[sel], set cnt = 0, go to COUNT. Otherwise stay in IDLE.
- COUNT, checked each cycle:
  - if sync[sel] != target: abort. No level change, no event, rr_ptr = sel+1 (mod N_BTN), go to IDLE.
  - else if cnt == STABLE_CNT-1: level[sel] <= target, evt_valid <= 1, evt_id <= sel, evt_dir <= target, go to EMIT.
  - else cnt <= cnt+1.
- EMIT: hold evt_valid, evt_id and evt_dir stable. On evt_valid & evt_ready: evt_valid <= 0, rr_ptr = sel+1 (mod N_BTN), go to IDLE.
- Only one button is examined at a time. Changes on other buttons stay pending; their level holds until they are scheduled.
- A button that bounces back to its old level before scheduling clears its own pending and is never counted.
- busy = (state != IDLE).

## Timing
- Reset (asynchronous, any time including mid-COUNT or EMIT): state = IDLE, level = 0, evt_valid = 0, evt_id = 0, evt_dir = 0, cnt = 0, sel = 0, rr_ptr = 0, synchronizers = 0, busy = 0. Any in-progress count or unaccepted event is discarded.
- Latency, single button, scheduler idle: raw change settled before edge 1 -> sync at edge 2 -> COUNT entered at edge 3 -> level and evt_valid update at edge STABLE_CNT+3 (edge 22 for default).
- Total stable sampling: STABLE_CNT cycles in COUNT.
- A mismatch on any COUNT cycle, including the final one, aborts; level is unchanged.
- Handshake: the event transfers on the rising edge where evt_valid & evt_ready. evt_ready high in the same cycle evt_valid rises means EMIT lasts 1 cycle. Next IDLE evaluation is the following cycle.
- The earliest next COUNT entry is 2 cycles after an event is accepted (EMIT->IDLE->COUNT).
- Backpressure: evt_ready low holds EMIT indefinitely; no other button is serviced.
- evt_valid is never deasserted without acceptance except by reset.
- Simultaneous pending: round-robin from rr_ptr. After servicing index N_BTN-1, rr_ptr wraps to 0.

## Test plan
- Clean press: button[1] 0->1 held, evt_ready=1 -> level[1]=1 at edge 22, evt_valid 1 cycle, evt_id=1, evt_dir=1; release yields evt_dir=0.
- Bounce reject: button[0] toggles every 5 cycles for 60 cycles, then stays 1 -> no event during toggling; exactly one press event, 22 cycles after the last toggle.
- Final-cycle glitch: button[2] held 1, then forced back to 0 for 1 cycle at COUNT cnt=18 -> abort, level[2]=0, no event, busy drops; rescheduled when stable again.
- Round-robin: buttons 0 and 3 pressed on the same cycle from reset -> event id 0, then id 3. Next simultaneous press of 0 and 2 with rr_ptr=0 (after wrap from 3) -> id 0, then id 2.
- Backpressure: evt_ready=0 for 100 cycles after a button[1] event while button[2] is pressed -> evt_valid/id/dir stable, level[2] stays 0. Raise evt_ready -> id 1 accepted, then id 2 event 21 cycles later.
- Async reset mid-COUNT and mid-EMIT: rst_n low asynchronously -> all outputs 0 immediately. After release, held buttons are re-debounced from scratch.
